// File: rtl/if_stage_fifo_pkg.sv
// Shared fetch-stage definitions: IF->ID bus layout and inst-SRAM encodings.
package if_stage_fifo_pkg;

    localparam int IF_TO_ID_WD     = 65;
    localparam int IF_BUS_INST_LSB = 0;
    localparam int IF_BUS_PC_LSB   = 32;
    localparam int IF_BUS_ADEF_BIT = 64;

    localparam logic [1:0] INST_SRAM_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_to_id_t;

endpackage

// File: rtl/if_stage_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count and a flush that clears it and suppresses
// a same-cycle push. Caller must not push into a full FIFO unless also popping.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_wptr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap keeps DEPTH==1 correct where a 1-bit pointer would overrun.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_cnt;

endmodule

// File: rtl/if_stage_fifo.sv
// Fetch stage: PC generator, split-transaction inst-bus master, instruction FIFO to ID.
// Optional macro IF_ADEF_EN: misaligned pc raises adef instead of fetching.
module if_stage_fifo
    import if_stage_fifo_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_allowin,
    output logic                   if_to_id_valid,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    input  logic                   br_taken,
    input  logic [31:0]            br_target,
    output logic                   inst_sram_req,
    output logic                   inst_sram_wr,
    output logic [1:0]             inst_sram_size,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic                   inst_sram_addr_ok,
    input  logic                   inst_sram_data_ok,
    input  logic [31:0]            inst_sram_rdata
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]  r_pc;
    logic [OCW-1:0] r_discard;
    logic [OCW-1:0] w_out;       // tag-queue occupancy is the outstanding count
    logic [OCW-1:0] w_out_next;
    logic [FCW-1:0] w_fifo_cnt;
    logic [31:0]  w_tag_pc;
    logic         w_space;
    logic         w_req;
    logic         w_accept;
    logic         w_resp_keep;
    logic         w_adef_push;
    logic         w_fifo_push;
    logic         w_fifo_pop;
    if_to_id_t    w_push_data;
    if_to_id_t    w_head;

    // Reserving a FIFO slot per in-flight request means data_ok never needs back-pressure.
    assign w_space = (32'(w_out) < MAX_OUTSTANDING) &&
                     (32'(w_fifo_cnt) + 32'(w_out) < FIFO_DEPTH);

`ifdef IF_ADEF_EN
    logic r_adef_done;
    logic w_misalign;

    assign w_misalign     = r_pc[1:0] != 2'b00;
    assign w_req          = ~reset & w_space & ~w_misalign;
    assign w_adef_push    = ~reset & w_misalign & ~r_adef_done & ~br_taken &
                            (w_out == '0) & (32'(w_fifo_cnt) < FIFO_DEPTH);
    assign inst_sram_addr = r_pc;

    // One adef record per misaligned target; the pc then sits until a redirect.
    always_ff @(posedge clk) begin
        if (reset || br_taken) r_adef_done <= 1'b0;
        else if (w_adef_push)  r_adef_done <= 1'b1;
    end
`else
    assign w_req          = ~reset & w_space;
    assign w_adef_push    = 1'b0;
    assign inst_sram_addr = {r_pc[31:2], 2'b00};
`endif

    assign inst_sram_req   = w_req;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = INST_SRAM_SIZE_WORD;
    assign inst_sram_wdata = 32'h0;

    assign w_accept    = w_req & inst_sram_addr_ok;
    assign w_resp_keep = inst_sram_data_ok & (r_discard == '0);
    assign w_out_next  = w_out + OCW'(w_accept) - OCW'(inst_sram_data_ok);

    assign w_fifo_push = (w_resp_keep | w_adef_push) & ~br_taken;
    assign w_push_data = w_adef_push ? '{adef: 1'b1, pc: r_pc, inst: 32'h0}
                                     : '{adef: 1'b0, pc: w_tag_pc, inst: inst_sram_rdata};

    assign if_to_id_valid = ~reset & (w_fifo_cnt != '0) & ~br_taken;
    assign w_fifo_pop     = if_to_id_valid & id_allowin;
    assign if_to_id_bus   = w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else if (br_taken) begin
            // Everything still in flight after this edge belongs to the old path.
            r_pc      <= br_target;
            r_discard <= w_out_next;
        end else begin
            if (w_accept) r_pc <= r_pc + 32'd4;
            if (inst_sram_data_ok && r_discard != '0) r_discard <= r_discard - OCW'(1);
        end
    end

    sync_fifo #(
        .WIDTH (IF_TO_ID_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (br_taken),
        .i_push  (w_fifo_push),
        .i_din   (w_push_data),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_head),
        .o_count (w_fifo_cnt)
    );

    // Tags keep tracking across redirects so discarded responses still pop in order.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk     (clk),
        .reset   (reset),
        .i_flush (1'b0),
        .i_push  (w_accept),
        .i_din   (r_pc),
        .i_pop   (inst_sram_data_ok),
        .o_dout  (w_tag_pc),
        .o_count (w_out)
    );

endmodule

// File: doc/if_stage_fifo.md
Name: if_stage_fifo

Overview:
- Parametrised successor fetch stage for the LoongArch pipeline.
- Replaces the single-register IF with three parts:
  - a PC generator,
  - a split-transaction instruction-bus master (req/addr_ok/data_ok),
  - an instruction FIFO feeding ID with the valid/allowin handshake.
- Supports multiple outstanding fetches and redirect-with-discard of in-flight responses.

Parameters:
- RESET_PC, 32'h1c00_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction-buffer entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, accepted-but-unreturned requests allowed (power of two, ≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_allowin  in  1  ID can accept an instruction this cycle
- if_to_id_valid  out  1  FIFO head valid toward ID
- if_to_id_bus  out  `IF_TO_ID_WD (65)  {adef, pc[31:0], inst[31:0]}
- br_taken  in  1  redirect request from ID, single-cycle pulse
- br_target  in  32  redirect address
- inst_sram_req  out  1  fetch request
- inst_sram_wr  out  1  tied 0
- inst_sram_size  out  2  tied 2'd2
- inst_sram_addr  out  32  fetch address (= pc)
- inst_sram_wdata  out  32  tied 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  read data valid (in-order return)
- inst_sram_rdata  in  32  read data

Behaviour:
- Reset (synchronous, any cycle including mid-transaction):
  - pc=RESET_PC.
  - FIFO empty; tag queue empty; outstanding=0; discard=0.
  - if_to_id_valid=0, inst_sram_req=0 during reset.
  - Responses arriving after reset release are not expected (bus reset together).
- Request rule: inst_sram_req = ~reset & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding < FIFO_DEPTH). This guarantees every live response has a free slot, so data_ok is never back-pressured.
- Accept = inst_sram_req & inst_sram_addr_ok.
  - Push pc into tag queue (depth MAX_OUTSTANDING).
  - pc <= pc+4, wrapping modulo 2^32.
- Response = inst_sram_data_ok; pop tag queue.
  - If discard>0: drop the response, discard--.
  - Else push {tag_pc, rdata} into FIFO.
- Counters: outstanding_next = outstanding + accept - data_ok.
- Output side:
  - if_to_id_valid = ~fifo_empty & ~br_taken.
  - Pop FIFO on if_to_id_valid & id_allowin.
  - Push and pop in the same cycle is legal, including when full, provided the request rule held.
- Redirect (br_taken=1):
  - pc <= br_target. Overrides the +4; a request accepted that cycle still used the old pc.
  - FIFO flushed. Any push that cycle is suppressed; no pop.
  - discard <= outstanding_next, i.e. every request in flight after this edge (including one accepted this cycle) is dropped on return.
  - Tag queue still tracks those entries normally.
  - Back-to-back redirects: each recomputes discard from outstanding_next; the last target wins.
- Bus protocol:
  - inst_sram_addr may change while req is held without addr_ok (redirect); the bus samples only on the handshake.
- Latency: reset release → first req next cycle; addr_ok → data_ok → FIFO → if_to_id_valid the cycle after data_ok.

Optional Feature:
- Macro IF_ADEF_EN.
- Defined:
  - If pc[1:0]!=0, no bus request is issued.
  - When FIFO has space and outstanding==0, push {adef=1, pc, 32'h0} directly.
  - Then pc stalls (no increment) until a redirect.
- Undefined:
  - adef bit is tied 0.
  - pc[1:0] is ignored on the bus (addr forced to {pc[31:2],2'b00}).

Decomposition:
- Shared header mycpu.h carries:
  - `IF_TO_ID_WD=65;
  - the bus field offsets;
  - the inst_sram_size encoding constant.
- One natural sub-module, sync_fifo (parametrised width/depth, count, flush input). Instantiate it twice:
  - the instruction FIFO (width 65);
  - the pc tag queue (width 32).

Test Plan:
- Reset, addr_ok=1 every cycle, data_ok 1 cycle later, id_allowin=1 → ID sees pc 1c000000, 1c000004, 1c000008 in consecutive cycles, insts match memory.
- id_allowin=0, FIFO_DEPTH=4, zero bus latency:
  - expected: req drops after fifo_count+outstanding=4;
  - expected: exactly 4 entries held, no loss;
  - expected: release drains in order.
- 2 outstanding (data_ok delayed 3 cycles), br_taken to 1c000100:
  - expected: both stale responses dropped;
  - expected: next valid to ID has pc=1c000100.
- br_taken in the same cycle as accept and data_ok → discard = outstanding_next, FIFO empty next cycle, no stale pc reaches ID.
- Reset asserted with FIFO holding 3 entries and 1 outstanding:
  - expected next cycle: if_to_id_valid=0, req=0;
  - expected: after release, fetch restarts at RESET_PC.
- IF_ADEF_EN, redirect to 1c000102 → no req issued; ID receives adef=1, pc=1c000102; pc holds until next redirect.
